vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single external VRAM port between the renderer (real-time, priority requester) and the MPU (background requester). Replaces the static MEM_CTRL[0] mux.
- Accepts at most one access per clock and registers the VRAM command outputs.
- Tracks in-flight reads through a fixed-latency pipeline so each read result returns only to its owner.
- Includes a starvation guard so continuous renderer traffic cannot lock out the MPU.

Parameters:
ADDR_WIDTH, 16, VRAM word address width
DATA_WIDTH, 16, VRAM data width
READ_LATENCY, 2, cycles from vram_en-high cycle to read data valid on vram_data_in (1..4)
MPU_MAX_WAIT, 8, consecutive denied MPU request cycles before MPU is forced to win (1..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
ren_req  in  1  renderer access request
ren_wr  in  1  1 = write, 0 = read
ren_be  in  2  byte enables, active-high
ren_addr  in  ADDR_WIDTH  renderer address
ren_data_in  in  DATA_WIDTH  renderer write data
ren_grant  out  1  renderer command accepted this cycle
ren_valid  out  1  rd_data holds renderer read result
mpu_req  in  1  MPU access request
mpu_wr  in  1  1 = write, 0 = read
mpu_be  in  2  byte enables, active-high
mpu_addr  in  ADDR_WIDTH  MPU address
mpu_data_in  in  DATA_WIDTH  MPU write data
mpu_grant  out  1  MPU command accepted this cycle
mpu_valid  out  1  rd_data holds MPU read result
rd_data  out  DATA_WIDTH  registered read return data, shared
vram_en  out  1  access strobe, active-high
vram_rd  out  1  read strobe, active-high
vram_wr  out  1  write strobe, active-high
vram_be  out  2  byte enables, active-high
vram_addr  out  ADDR_WIDTH  VRAM address
vram_data_out  out  DATA_WIDTH  VRAM write data
vram_data_in  in  DATA_WIDTH  VRAM read data

Behaviour:
- Reset values: all outputs 0; wait counter 0; read tag pipeline cleared.
- Reset is asynchronous and may assert mid-operation. In-flight reads are dropped and no valid is issued for them.
- Grants are combinational. force_mpu = (wait_cnt == MPU_MAX_WAIT).
  - ren_grant = ren_req & ~(force_mpu & mpu_req).
  - mpu_grant = mpu_req & (~ren_req | force_mpu).
  - At most one grant is high in any cycle.
- Requester handshake:
  - The requester holds req and its command stable until grant.
  - A command is accepted on the clock edge where grant = 1.
  - The requester may present a new command in the next cycle, so back-to-back grants to the same requester are allowed.
- Issue: if a command is accepted at edge E, the following cycle has vram_en = 1, vram_rd = ~wr, vram_wr = wr, and be, addr and data taken from the winner.
  - With no grant, vram_en, vram_rd, vram_wr and vram_be go to 0.
  - With no grant, vram_addr and vram_data_out hold their last value.
  - On reads, vram_data_out holds its last value.
- Read return:
  - A READ_LATENCY-deep shift register carries {is_read, owner} for each issued cycle.
  - For a read with vram_en high in cycle T, vram_data_in is sampled at the end of cycle T+READ_LATENCY-1.
  - rd_data and the owner's valid are high for exactly one cycle, T+READ_LATENCY.
  - Grant-to-valid latency is READ_LATENCY+1 cycles after the grant cycle.
  - Writes produce no valid.
- Starvation guard:
  - wait_cnt (8 bits) increments on each cycle with mpu_req = 1 and mpu_grant = 0.
  - It saturates at MPU_MAX_WAIT.
  - It clears on mpu_grant, or when mpu_req = 0.
- Simultaneous requests:
  - With force_mpu = 0, the renderer wins.
  - With force_mpu = 1, the MPU wins, ren_grant = 0 that cycle, and the renderer wins the next cycle.
- Interleaving: renderer and MPU reads may be interleaved in the pipeline. Valids are returned in issue order and each goes only to its owner.

Test Plan:
- Reset only, no requests for 10 cycles -> all outputs 0, vram_en never rises.
- MPU write alone (addr 0x0123, data 0xBEEF, be 2'b11) -> mpu_grant same cycle; next cycle vram_en = 1, vram_wr = 1, addr 0x0123, data 0xBEEF; mpu_valid never rises.
- Renderer read alone (addr 0x0040), model returns 0x5A5A with READ_LATENCY = 2 -> ren_valid exactly 3 cycles after grant, rd_data = 0x5A5A, mpu_valid = 0.
- ren_req and mpu_req both held continuously with MPU_MAX_WAIT = 8 -> renderer granted 8 cycles, then MPU granted exactly once, then renderer again; the pattern repeats with no cycle granting both.
- Alternating granted reads R(ren, 0x10) then M(mpu, 0x20), model data = address -> ren_valid with 0x0010 in one cycle, mpu_valid with 0x0020 in the next.
- Renderer read granted, reset pulsed 1 cycle later -> outputs return to 0 asynchronously; ren_valid never asserts for the dropped read.

Source files
------------

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Purpose:
//   Shares the single external VRAM port between the renderer (real-time,
//   priority requester) and the MPU (background requester). At most one
//   command is accepted per clock. The VRAM command outputs are registered.
//   Read results are steered back to their owner through a fixed-latency tag
//   pipeline. A starvation guard forces an MPU win after MPU_MAX_WAIT
//   consecutive denied MPU request cycles.
//
// Handshake (both requesters):
//   A requester raises req with its command (wr/be/addr/data) and holds them
//   stable until grant is high. The command is accepted on the rising clock
//   edge where grant = 1. A new command may be presented in the very next
//   cycle, so back-to-back grants to one requester are allowed. Grants are
//   combinational and at most one is high in any cycle.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   ren_req/wr/be/addr/data_in  renderer command in
//   ren_grant, ren_valid        renderer accept strobe, read result valid
//   mpu_req/wr/be/addr/data_in  MPU command in
//   mpu_grant, mpu_valid        MPU accept strobe, read result valid
//   rd_data                     registered read data, shared by both owners
//   vram_en/rd/wr/be/addr/data_out  registered VRAM command
//   vram_data_in                VRAM read data
// -----------------------------------------------------------------------------
module vram_arbiter #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 16,
   parameter int READ_LATENCY = 2,
   parameter int MPU_MAX_WAIT = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   // renderer
   input  logic                  ren_req,
   input  logic                  ren_wr,
   input  logic [1:0]            ren_be,
   input  logic [ADDR_WIDTH-1:0] ren_addr,
   input  logic [DATA_WIDTH-1:0] ren_data_in,
   output logic                  ren_grant,
   output logic                  ren_valid,
   // MPU
   input  logic                  mpu_req,
   input  logic                  mpu_wr,
   input  logic [1:0]            mpu_be,
   input  logic [ADDR_WIDTH-1:0] mpu_addr,
   input  logic [DATA_WIDTH-1:0] mpu_data_in,
   output logic                  mpu_grant,
   output logic                  mpu_valid,
   // shared read return
   output logic [DATA_WIDTH-1:0] rd_data,
   // VRAM port
   output logic                  vram_en,
   output logic                  vram_rd,
   output logic                  vram_wr,
   output logic [1:0]            vram_be,
   output logic [ADDR_WIDTH-1:0] vram_addr,
   output logic [DATA_WIDTH-1:0] vram_data_out,
   input  logic [DATA_WIDTH-1:0] vram_data_in
);

   localparam logic [7:0] WAIT_LIMIT = 8'(MPU_MAX_WAIT);

   // starvation guard
   logic [7:0]            r_wait_cnt;
   logic                  w_force_mpu;

   // arbitration and winner mux
   logic                  w_ren_grant;
   logic                  w_mpu_grant;
   logic                  w_any_grant;
   logic                  w_sel_wr;
   logic [1:0]            w_sel_be;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [DATA_WIDTH-1:0] w_sel_data;

   // registered VRAM command
   logic                  r_vram_en;
   logic                  r_vram_rd;
   logic                  r_vram_wr;
   logic [1:0]            r_vram_be;
   logic [ADDR_WIDTH-1:0] r_vram_addr;
   logic [DATA_WIDTH-1:0] r_vram_data_out;

   // read tag pipeline: bit 0 is the newest stage, bit READ_LATENCY-1 is the
   // stage whose data is on vram_data_in during the current cycle
   logic [READ_LATENCY-1:0] r_tag_rd;
   logic [READ_LATENCY-1:0] r_tag_mpu;

   // read return
   logic                  r_ren_valid;
   logic                  r_mpu_valid;
   logic [DATA_WIDTH-1:0] r_rd_data;

   // ---------------------------------------------------------------------------
   // Arbitration. The renderer wins ties unless the MPU has waited its limit.
   // Grants are held low in reset so every output reads 0 while reset is high.
   // ---------------------------------------------------------------------------
   assign w_force_mpu = (r_wait_cnt == WAIT_LIMIT);
   assign w_ren_grant = ~reset & ren_req & ~(w_force_mpu & mpu_req);
   assign w_mpu_grant = ~reset & mpu_req & (~ren_req | w_force_mpu);
   assign w_any_grant = w_ren_grant | w_mpu_grant;

   assign w_sel_wr    = w_mpu_grant ? mpu_wr      : ren_wr;
   assign w_sel_be    = w_mpu_grant ? mpu_be      : ren_be;
   assign w_sel_addr  = w_mpu_grant ? mpu_addr    : ren_addr;
   assign w_sel_data  = w_mpu_grant ? mpu_data_in : ren_data_in;

   // ---------------------------------------------------------------------------
   // Starvation counter: counts consecutive denied MPU request cycles and
   // saturates at the limit; any MPU win or an idle MPU clears it.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait_cnt <= 8'd0;
      end else if (!mpu_req || w_mpu_grant) begin
         r_wait_cnt <= 8'd0;
      end else if (r_wait_cnt != WAIT_LIMIT) begin
         r_wait_cnt <= r_wait_cnt + 8'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Command issue. Address and write data hold when idle so the VRAM bus does
   // not toggle needlessly; write data also holds across reads.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vram_en       <= 1'b0;
         r_vram_rd       <= 1'b0;
         r_vram_wr       <= 1'b0;
         r_vram_be       <= 2'b00;
         r_vram_addr     <= '0;
         r_vram_data_out <= '0;
      end else begin
         r_vram_en <= w_any_grant;
         r_vram_rd <= w_any_grant & ~w_sel_wr;
         r_vram_wr <= w_any_grant & w_sel_wr;
         r_vram_be <= w_any_grant ? w_sel_be : 2'b00;
         if (w_any_grant) begin
            r_vram_addr <= w_sel_addr;
         end
         if (w_any_grant && w_sel_wr) begin
            r_vram_data_out <= w_sel_data;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Read tag pipeline. A tag enters stage 0 on the grant edge, i.e. it sits in
   // stage 0 during the vram_en cycle T and in stage READ_LATENCY-1 during
   // cycle T+READ_LATENCY-1, when the VRAM data is valid. Clearing on reset
   // drops every in-flight read.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tag_rd  <= '0;
         r_tag_mpu <= '0;
      end else begin
         r_tag_rd  <= (r_tag_rd << 1)  | READ_LATENCY'(w_any_grant & ~w_sel_wr);
         r_tag_mpu <= (r_tag_mpu << 1) | READ_LATENCY'(w_mpu_grant);
      end
   end

   // ---------------------------------------------------------------------------
   // Read return: capture VRAM data for the oldest tag and raise only the
   // owner's valid for one cycle. rd_data holds between reads.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ren_valid <= 1'b0;
         r_mpu_valid <= 1'b0;
         r_rd_data   <= '0;
      end else begin
         r_ren_valid <= r_tag_rd[READ_LATENCY-1] & ~r_tag_mpu[READ_LATENCY-1];
         r_mpu_valid <= r_tag_rd[READ_LATENCY-1] &  r_tag_mpu[READ_LATENCY-1];
         if (r_tag_rd[READ_LATENCY-1]) begin
            r_rd_data <= vram_data_in;
         end
      end
   end

   assign ren_grant     = w_ren_grant;
   assign mpu_grant     = w_mpu_grant;
   assign ren_valid     = r_ren_valid;
   assign mpu_valid     = r_mpu_valid;
   assign rd_data       = r_rd_data;
   assign vram_en       = r_vram_en;
   assign vram_rd       = r_vram_rd;
   assign vram_wr       = r_vram_wr;
   assign vram_be       = r_vram_be;
   assign vram_addr     = r_vram_addr;
   assign vram_data_out = r_vram_data_out;

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
//
// Bench for vram_arbiter: a behavioural VRAM model, a cycle scoreboard built
// from the arbitration rules (who wins, when the command appears, when and to
// whom read data returns), a vector table, hand-written corner sequences and
// a randomized two-requester phase.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int RL = 2;
   localparam int MW = 8;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------- DUT
   logic          ren_req, ren_wr, ren_grant, ren_valid;
   logic [1:0]    ren_be;
   logic [AW-1:0] ren_addr;
   logic [DW-1:0] ren_data_in;
   logic          mpu_req, mpu_wr, mpu_grant, mpu_valid;
   logic [1:0]    mpu_be;
   logic [AW-1:0] mpu_addr;
   logic [DW-1:0] mpu_data_in;
   logic [DW-1:0] rd_data;
   logic          vram_en, vram_rd, vram_wr;
   logic [1:0]    vram_be;
   logic [AW-1:0] vram_addr;
   logic [DW-1:0] vram_data_out;
   logic [DW-1:0] vram_data_in = '0;

   vram_arbiter #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .READ_LATENCY(RL),
      .MPU_MAX_WAIT(MW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ren_req      (ren_req),
      .ren_wr       (ren_wr),
      .ren_be       (ren_be),
      .ren_addr     (ren_addr),
      .ren_data_in  (ren_data_in),
      .ren_grant    (ren_grant),
      .ren_valid    (ren_valid),
      .mpu_req      (mpu_req),
      .mpu_wr       (mpu_wr),
      .mpu_be       (mpu_be),
      .mpu_addr     (mpu_addr),
      .mpu_data_in  (mpu_data_in),
      .mpu_grant    (mpu_grant),
      .mpu_valid    (mpu_valid),
      .rd_data      (rd_data),
      .vram_en      (vram_en),
      .vram_rd      (vram_rd),
      .vram_wr      (vram_wr),
      .vram_be      (vram_be),
      .vram_addr    (vram_addr),
      .vram_data_out(vram_data_out),
      .vram_data_in (vram_data_in)
   );

   // ---------------------------------------------------------------- checking
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                           input logic [DW-1:0] new_v,
                                           input logic [1:0]    be);
      merge = {be[1] ? new_v[15:8] : old_v[15:8], be[0] ? new_v[7:0] : old_v[7:0]};
   endfunction

   // ---------------------------------------------------------------- VRAM model
   // Unwritten words read back as their own address. A read seen in cycle T
   // has its data driven during cycle T+RL-1; otherwise the bus carries junk.
   logic [DW-1:0] vmem [logic [AW-1:0]];
   logic          rv_ring [16];
   logic [DW-1:0] rd_ring [16];

   always @(negedge clk) begin
      int slot;
      int src;
      slot = cyc % 16;
      rv_ring[slot] = vram_en && vram_rd;
      rd_ring[slot] = vmem.exists(vram_addr) ? vmem[vram_addr] : vram_addr;
      if (vram_en && vram_wr)
         vmem[vram_addr] = merge(vmem.exists(vram_addr) ? vmem[vram_addr] : vram_addr,
                                 vram_data_out, vram_be);
      src = cyc - (RL - 1);
      if (src >= 0 && rv_ring[src % 16] === 1'b1)
         vram_data_in = rd_ring[src % 16];
      else
         vram_data_in = DW'($urandom);
   end

   // ---------------------------------------------------------------- scoreboard
   typedef struct {
      int            due;
      logic          mpu;
      logic [DW-1:0] data;
   } rd_exp_t;

   rd_exp_t       exp_q[$];
   logic [DW-1:0] ref_mem [logic [AW-1:0]];
   int            m_wait = 0;
   logic          m_en = 1'b0, m_wr = 1'b0;
   logic [1:0]    m_be = 2'b00;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_dout = '0;

   always @(negedge clk) begin
      logic          force_m, eg_r, eg_m, er, em, w_wr;
      logic [DW-1:0] ed, w_data, old_v;
      logic [AW-1:0] w_addr;
      logic [1:0]    w_be;
      rd_exp_t       e;
      if (reset) begin
         exp_q.delete();
         m_wait = 0;
         m_en   = 1'b0;
         m_wr   = 1'b0;
         m_be   = 2'b00;
         m_addr = '0;
         m_dout = '0;
      end else begin
         // who wins this cycle
         force_m = (m_wait == MW);
         if (ren_req && mpu_req) begin
            eg_m = force_m;
            eg_r = !force_m;
         end else begin
            eg_r = ren_req;
            eg_m = mpu_req;
         end
         chk("ren_grant", ren_grant, eg_r);
         chk("mpu_grant", mpu_grant, eg_m);

         // command accepted last cycle appears now
         chk("vram_en", vram_en, m_en);
         chk("vram_rd", vram_rd, m_en & ~m_wr);
         chk("vram_wr", vram_wr, m_en & m_wr);
         chk("vram_be", vram_be, m_be);
         chk("vram_addr", vram_addr, m_addr);
         chk("vram_data_out", vram_data_out, m_dout);

         // read returns, in issue order, to their owner only
         er = 1'b0;
         em = 1'b0;
         ed = '0;
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e  = exp_q.pop_front();
            er = ~e.mpu;
            em = e.mpu;
            ed = e.data;
         end
         chk("ren_valid", ren_valid, er);
         chk("mpu_valid", mpu_valid, em);
         if (er || em) chk("rd_data", rd_data, ed);

         // what the next cycle should show
         m_en = eg_r | eg_m;
         m_wr = 1'b0;
         m_be = 2'b00;
         if (eg_r || eg_m) begin
            w_wr   = eg_m ? mpu_wr      : ren_wr;
            w_be   = eg_m ? mpu_be      : ren_be;
            w_addr = eg_m ? mpu_addr    : ren_addr;
            w_data = eg_m ? mpu_data_in : ren_data_in;
            m_wr   = w_wr;
            m_be   = w_be;
            m_addr = w_addr;
            old_v  = ref_mem.exists(w_addr) ? ref_mem[w_addr] : w_addr;
            if (w_wr) begin
               m_dout          = w_data;
               ref_mem[w_addr] = merge(old_v, w_data, w_be);
            end else begin
               e.due  = cyc + RL + 1;
               e.mpu  = eg_m;
               e.data = old_v;
               exp_q.push_back(e);
            end
         end
         if (!mpu_req || eg_m) m_wait = 0;
         else if (m_wait < MW) m_wait++;
      end
   end

   // ---------------------------------------------------------------- drivers
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      ren_req = 1'b0;
      mpu_req = 1'b0;
   endtask

   task automatic set_ren(input logic wr, input logic [1:0] be, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      ren_req = 1'b1; ren_wr = wr; ren_be = be; ren_addr = a; ren_data_in = d;
   endtask

   task automatic set_mpu(input logic wr, input logic [1:0] be, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      mpu_req = 1'b1; mpu_wr = wr; mpu_be = be; mpu_addr = a; mpu_data_in = d;
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_ren_grant"}, ren_grant, 0);
      chk({pfx, "_mpu_grant"}, mpu_grant, 0);
      chk({pfx, "_ren_valid"}, ren_valid, 0);
      chk({pfx, "_mpu_valid"}, mpu_valid, 0);
      chk({pfx, "_rd_data"}, rd_data, 0);
      chk({pfx, "_vram_en"}, vram_en, 0);
      chk({pfx, "_vram_rd"}, vram_rd, 0);
      chk({pfx, "_vram_wr"}, vram_wr, 0);
      chk({pfx, "_vram_be"}, vram_be, 0);
      chk({pfx, "_vram_addr"}, vram_addr, 0);
      chk({pfx, "_vram_data_out"}, vram_data_out, 0);
   endtask

   // ---------------------------------------------------------------- vectors
   typedef struct {
      logic rr, rw; logic [1:0] rbe; logic [15:0] ra, rdat;
      logic mr, mw; logic [1:0] mbe; logic [15:0] ma, mdat;
      logic eg_r, eg_m, e_en, e_rd, e_wr;
      logic [1:0] e_be; logic [15:0] e_addr, e_dout;
   } vec_t;

   vec_t vecs [7];

   initial begin
      logic r_done, m_done;

      vecs[0] = '{1'b0,1'b0,2'b00,16'h0000,16'h0000, 1'b1,1'b1,2'b11,16'h0123,16'hBEEF,
                  1'b0,1'b1,1'b1,1'b0,1'b1, 2'b11,16'h0123,16'hBEEF};
      vecs[1] = '{1'b1,1'b0,2'b11,16'h0040,16'h0000, 1'b0,1'b0,2'b00,16'h0000,16'h0000,
                  1'b1,1'b0,1'b1,1'b1,1'b0, 2'b11,16'h0040,16'hBEEF};
      vecs[2] = '{1'b1,1'b1,2'b01,16'h0200,16'h1111, 1'b1,1'b0,2'b11,16'h0300,16'h0000,
                  1'b1,1'b0,1'b1,1'b0,1'b1, 2'b01,16'h0200,16'h1111};
      vecs[3] = '{1'b1,1'b0,2'b10,16'h0400,16'h0000, 1'b1,1'b1,2'b11,16'h0500,16'h2222,
                  1'b1,1'b0,1'b1,1'b1,1'b0, 2'b10,16'h0400,16'h1111};
      vecs[4] = '{1'b0,1'b0,2'b00,16'h0000,16'h0000, 1'b1,1'b0,2'b00,16'h0600,16'h0000,
                  1'b0,1'b1,1'b1,1'b1,1'b0, 2'b00,16'h0600,16'h1111};
      vecs[5] = '{1'b1,1'b1,2'b10,16'h0700,16'h3333, 1'b0,1'b0,2'b00,16'h0000,16'h0000,
                  1'b1,1'b0,1'b1,1'b0,1'b1, 2'b10,16'h0700,16'h3333};
      vecs[6] = '{1'b0,1'b0,2'b11,16'h0800,16'h4444, 1'b0,1'b0,2'b11,16'h0900,16'h5555,
                  1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,16'h0700,16'h3333};

      vmem[16'h0040]    = 16'h5A5A;
      ref_mem[16'h0040] = 16'h5A5A;

      reset = 1'b1;
      ren_req = 1'b0; ren_wr = 1'b0; ren_be = 2'b00; ren_addr = '0; ren_data_in = '0;
      mpu_req = 1'b0; mpu_wr = 1'b0; mpu_be = 2'b00; mpu_addr = '0; mpu_data_in = '0;

      // reset, then 10 idle cycles
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("in_reset");
      reset = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("idle_vram_en", vram_en, 0);
      end
      chk_all_zero("after_idle");

      // vector table: one request cycle, then one idle cycle to see the command
      for (int i = 0; i < 7; i++) begin
         step();
         ren_req = vecs[i].rr; ren_wr = vecs[i].rw; ren_be = vecs[i].rbe;
         ren_addr = vecs[i].ra; ren_data_in = vecs[i].rdat;
         mpu_req = vecs[i].mr; mpu_wr = vecs[i].mw; mpu_be = vecs[i].mbe;
         mpu_addr = vecs[i].ma; mpu_data_in = vecs[i].mdat;
         @(negedge clk);
         chk($sformatf("vec%0d_ren_grant", i), ren_grant, vecs[i].eg_r);
         chk($sformatf("vec%0d_mpu_grant", i), mpu_grant, vecs[i].eg_m);
         step();
         idle_all();
         @(negedge clk);
         chk($sformatf("vec%0d_vram_en", i), vram_en, vecs[i].e_en);
         chk($sformatf("vec%0d_vram_rd", i), vram_rd, vecs[i].e_rd);
         chk($sformatf("vec%0d_vram_wr", i), vram_wr, vecs[i].e_wr);
         chk($sformatf("vec%0d_vram_be", i), vram_be, vecs[i].e_be);
         chk($sformatf("vec%0d_vram_addr", i), vram_addr, vecs[i].e_addr);
         chk($sformatf("vec%0d_vram_data_out", i), vram_data_out, vecs[i].e_dout);
      end
      repeat (4) step();

      // renderer read alone: valid exactly RL+1 cycles after the grant
      set_ren(1'b0, 2'b11, 16'h0040, 16'h0000);
      @(negedge clk);
      chk("lat_ren_grant", ren_grant, 1);
      step();
      idle_all();
      for (int k = 1; k <= RL + 1; k++) begin
         if (k > 1) @(negedge clk);
         else @(negedge clk);
         chk($sformatf("lat_ren_valid_k%0d", k), ren_valid, (k == RL + 1) ? 1 : 0);
         chk($sformatf("lat_mpu_valid_k%0d", k), mpu_valid, 0);
         if (k == RL + 1) chk("lat_rd_data", rd_data, 16'h5A5A);
      end
      repeat (3) step();

      // alternating reads: renderer 0x10 then MPU 0x20
      set_ren(1'b0, 2'b11, 16'h0010, 16'h0000);
      @(negedge clk);
      chk("alt_ren_grant", ren_grant, 1);
      step();
      ren_req = 1'b0;
      set_mpu(1'b0, 2'b11, 16'h0020, 16'h0000);
      @(negedge clk);
      chk("alt_mpu_grant", mpu_grant, 1);
      step();
      idle_all();
      @(negedge clk);
      chk("alt_early_ren_valid", ren_valid, 0);
      @(negedge clk);
      chk("alt_ren_valid", ren_valid, 1);
      chk("alt_ren_data", rd_data, 16'h0010);
      chk("alt_ren_only", mpu_valid, 0);
      @(negedge clk);
      chk("alt_mpu_valid", mpu_valid, 1);
      chk("alt_mpu_data", rd_data, 16'h0020);
      chk("alt_mpu_only", ren_valid, 0);
      repeat (3) step();

      // starvation guard: both requesters held for three full rounds
      set_ren(1'b0, 2'b11, 16'h000B, 16'h0000);
      set_mpu(1'b0, 2'b11, 16'h000A, 16'h0000);
      for (int k = 0; k < 3 * (MW + 1); k++) begin
         @(negedge clk);
         chk($sformatf("starve_ren_grant_k%0d", k), ren_grant, (k % (MW + 1) != MW) ? 1 : 0);
         chk($sformatf("starve_mpu_grant_k%0d", k), mpu_grant, (k % (MW + 1) == MW) ? 1 : 0);
         step();
      end
      idle_all();
      repeat (6) step();

      // reset one cycle after a granted renderer read drops that read
      set_ren(1'b0, 2'b11, 16'h0040, 16'h0000);
      @(negedge clk);
      chk("rst_mid_ren_grant", ren_grant, 1);
      step();
      idle_all();
      reset = 1'b1;
      #1;
      chk_all_zero("rst_mid");
      step();
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("rst_dropped_ren_valid_k%0d", k), ren_valid, 0);
      end

      // random traffic from both requesters, honouring hold-until-grant
      step();
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         r_done = ren_req && ren_grant;
         m_done = mpu_req && mpu_grant;
         step();
         if (!ren_req || r_done) begin
            if ($urandom_range(0, 99) < 70)
               set_ren(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       AW'($urandom_range(0, 15)), DW'($urandom));
            else
               ren_req = 1'b0;
         end
         if (!mpu_req || m_done) begin
            if ($urandom_range(0, 99) < 50)
               set_mpu(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       AW'($urandom_range(0, 15)), DW'($urandom));
            else
               mpu_req = 1'b0;
         end
      end
      @(negedge clk);
      step();
      idle_all();
      repeat (RL + 6) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
